// File: rtl/eth_udp_pkt_gen.sv
// rtl/eth_udp_pkt_gen.sv - IPv4/UDP header builder feeding the RMII transmit FIFO; optional padding via ETH_UDP_PAD_EN
module eth_udp_pkt_gen #(
  parameter logic [31:0] pSRC_IP   = 32'hC0A80164,
  parameter logic [31:0] pDST_IP   = 32'hC0A801FF,
  parameter logic [15:0] pSRC_PORT = 16'd5000,
  parameter logic [15:0] pDST_PORT = 16'd5001,
  parameter int          pMAX_LEN  = 1472
) (
  input  logic        Clk_i,
  input  logic        Rst_n_i,
  input  logic        Start_i,
  input  logic [10:0] Payload_Len_i,
  output logic        Busy_o,
  output logic        Len_Err_o,
  input  logic [7:0]  Pld_Byte_i,
  input  logic        Pld_Valid_i,
  output logic        Pld_Ready_o,
  input  logic        Fifo_Afull_i,
  output logic [7:0]  Eth_Byte_o,
  output logic        Eth_Byte_Valid_o,
  output logic        Eth_Pkt_Rdy_o
);

`ifdef ETH_UDP_PAD_EN
  typedef enum logic [2:0] {IDLE, CSUM, HDR, PLD, PAD, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, CSUM, HDR, PLD, DONE} state_t;
`endif

  state_t      state_q;
  logic [10:0] len_q;
  logic [15:0] id_q;
  logic [19:0] acc_q;
  logic [15:0] csum_q;
  logic [4:0]  step_q;
  logic [10:0] cnt_q;
  logic [7:0]  eth_byte_q;
  logic        eth_valid_q;
  logic        pkt_rdy_q;
  logic        busy_q;
  logic        len_err_q;

  logic [15:0] tot_len_d;
  logic [15:0] udp_len_d;
  logic [15:0] csum_word_d;
  logic [7:0]  hdr_byte_d;
  logic [19:0] fold_sum_d;
  logic        len_ok_d;

  assign tot_len_d  = 16'd28 + {5'd0, len_q};
  assign udp_len_d  = 16'd8 + {5'd0, len_q};
  assign fold_sum_d = {4'd0, acc_q[15:0]} + {16'd0, acc_q[19:16]};
  assign len_ok_d   = (Payload_Len_i != 11'd0) && (32'(Payload_Len_i) <= pMAX_LEN);

  // Header word fed into the checksum adder on each CSUM step (checksum field counted as zero)
  always_comb begin
    csum_word_d = 16'h0000;
    case (step_q)
      5'd0:    csum_word_d = 16'h4500;
      5'd1:    csum_word_d = tot_len_d;
      5'd2:    csum_word_d = id_q;
      5'd3:    csum_word_d = 16'h4000;
      5'd4:    csum_word_d = 16'h4011;
      5'd6:    csum_word_d = pSRC_IP[31:16];
      5'd7:    csum_word_d = pSRC_IP[15:0];
      5'd8:    csum_word_d = pDST_IP[31:16];
      5'd9:    csum_word_d = pDST_IP[15:0];
      default: csum_word_d = 16'h0000;
    endcase
  end

  // IPv4 + UDP header byte selected by the header byte index, network order
  always_comb begin
    hdr_byte_d = 8'h00;
    case (step_q)
      5'd0:    hdr_byte_d = 8'h45;
      5'd2:    hdr_byte_d = tot_len_d[15:8];
      5'd3:    hdr_byte_d = tot_len_d[7:0];
      5'd4:    hdr_byte_d = id_q[15:8];
      5'd5:    hdr_byte_d = id_q[7:0];
      5'd6:    hdr_byte_d = 8'h40;
      5'd8:    hdr_byte_d = 8'h40;
      5'd9:    hdr_byte_d = 8'h11;
      5'd10:   hdr_byte_d = csum_q[15:8];
      5'd11:   hdr_byte_d = csum_q[7:0];
      5'd12:   hdr_byte_d = pSRC_IP[31:24];
      5'd13:   hdr_byte_d = pSRC_IP[23:16];
      5'd14:   hdr_byte_d = pSRC_IP[15:8];
      5'd15:   hdr_byte_d = pSRC_IP[7:0];
      5'd16:   hdr_byte_d = pDST_IP[31:24];
      5'd17:   hdr_byte_d = pDST_IP[23:16];
      5'd18:   hdr_byte_d = pDST_IP[15:8];
      5'd19:   hdr_byte_d = pDST_IP[7:0];
      5'd20:   hdr_byte_d = pSRC_PORT[15:8];
      5'd21:   hdr_byte_d = pSRC_PORT[7:0];
      5'd22:   hdr_byte_d = pDST_PORT[15:8];
      5'd23:   hdr_byte_d = pDST_PORT[7:0];
      5'd24:   hdr_byte_d = udp_len_d[15:8];
      5'd25:   hdr_byte_d = udp_len_d[7:0];
      default: hdr_byte_d = 8'h00;
    endcase
  end

  // Packet sequencer: checksum, header, payload (and padding), then the ready pulse
  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      state_q     <= IDLE;
      len_q       <= '0;
      id_q        <= '0;
      acc_q       <= '0;
      csum_q      <= '0;
      step_q      <= '0;
      cnt_q       <= '0;
      eth_byte_q  <= '0;
      eth_valid_q <= 1'b0;
      pkt_rdy_q   <= 1'b0;
      busy_q      <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      eth_valid_q <= 1'b0;
      pkt_rdy_q   <= 1'b0;
      len_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          // busy_q still high here during the ready-pulse cycle, so Start is ignored then
          if (Start_i && !busy_q) begin
            if (len_ok_d) begin
              len_q   <= Payload_Len_i;
              busy_q  <= 1'b1;
              acc_q   <= '0;
              step_q  <= '0;
              state_q <= CSUM;
            end else begin
              len_err_q <= 1'b1;
            end
          end
        end
        CSUM: begin
          step_q <= step_q + 5'd1;
          if (step_q < 5'd10) begin
            acc_q <= acc_q + {4'd0, csum_word_d};
          end else if (step_q == 5'd10) begin
            acc_q <= fold_sum_d;
          end else begin
            csum_q  <= ~fold_sum_d[15:0];
            step_q  <= '0;
            state_q <= HDR;
          end
        end
        HDR: begin
          if (!Fifo_Afull_i) begin
            eth_byte_q  <= hdr_byte_d;
            eth_valid_q <= 1'b1;
            if (step_q == 5'd27) begin
              step_q  <= '0;
              cnt_q   <= len_q;
              state_q <= PLD;
            end else begin
              step_q <= step_q + 5'd1;
            end
          end
        end
        PLD: begin
          if (Pld_Valid_i && !Fifo_Afull_i) begin
            eth_byte_q  <= Pld_Byte_i;
            eth_valid_q <= 1'b1;
            cnt_q       <= cnt_q - 11'd1;
            if (cnt_q == 11'd1) begin
`ifdef ETH_UDP_PAD_EN
              if (len_q < 11'd18) begin
                cnt_q   <= 11'd18 - len_q;
                state_q <= PAD;
              end else begin
                state_q <= DONE;
              end
`else
              state_q <= DONE;
`endif
            end
          end
        end
`ifdef ETH_UDP_PAD_EN
        PAD: begin
          if (!Fifo_Afull_i) begin
            eth_byte_q  <= 8'h00;
            eth_valid_q <= 1'b1;
            cnt_q       <= cnt_q - 11'd1;
            if (cnt_q == 11'd1) begin
              state_q <= DONE;
            end
          end
        end
`endif
        DONE: begin
          pkt_rdy_q <= 1'b1;
          id_q      <= id_q + 16'd1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Pld_Ready_o      = (state_q == PLD) && !Fifo_Afull_i;
  assign Busy_o           = busy_q;
  assign Len_Err_o        = len_err_q;
  assign Eth_Byte_o       = eth_byte_q;
  assign Eth_Byte_Valid_o = eth_valid_q;
  assign Eth_Pkt_Rdy_o    = pkt_rdy_q;

endmodule

// File: doc/eth_udp_pkt_gen.md
Name: eth_udp_pkt_gen

Overview:
Upstream stage of the RMII transmit path. It takes a payload length and a byte stream of user payload, and prepends a 20-byte IPv4 header (with computed header checksum) and an 8-byte UDP header. It writes the resulting bytes into the transmit path's payload FIFO via the Eth_Byte/Eth_Byte_Valid interface, then pulses Eth_Pkt_Rdy so the transmitter frames and sends the packet.

Parameters:
pSRC_IP, 32'hC0A80164, source IPv4 address (192.168.1.100)
pDST_IP, 32'hC0A801FF, destination IPv4 address (192.168.1.255)
pSRC_PORT, 16'd5000, UDP source port
pDST_PORT, 16'd5001, UDP destination port
pMAX_LEN, 1472, maximum accepted payload length in bytes

Ports:
Clk  in  1  system clock (50 MHz RMII reference)
Rst_n  in  1  asynchronous active-low reset
Start  in  1  single-cycle request to build one packet
Payload_Len  in  11  UDP payload byte count, sampled when Start is accepted
Busy  out  1  high from Start acceptance until the Eth_Pkt_Rdy cycle inclusive
Len_Err  out  1  one-cycle pulse when Start is rejected for a bad length
Pld_Byte  in  8  user payload byte
Pld_Valid  in  1  Pld_Byte is valid
Pld_Ready  out  1  payload byte is consumed when Pld_Valid & Pld_Ready
Fifo_Afull  in  1  almost-full from the transmit FIFO; stalls all writes
Eth_Byte  out  8  byte written to the transmit FIFO
Eth_Byte_Valid  out  1  FIFO write strobe
Eth_Pkt_Rdy  out  1  one-cycle pulse: full packet is in the FIFO

Behaviour:
- Reset: the clock and reset are decided as above; Rst_n is asynchronous and active-low. While Rst_n is low, all outputs are 0, the state is IDLE, and the IP identification counter is 0. A reset mid-packet abandons the packet with no Eth_Pkt_Rdy; the FIFO shares this reset.
- IDLE:
  - Start with Payload_Len in 1..pMAX_LEN: latch the length and go to CSUM.
  - Start with Payload_Len = 0 or > pMAX_LEN: Len_Err = 1 on the next cycle, stay IDLE.
  - Start while Busy is ignored.
- CSUM:
  - Ones-complement sum of the 10 header words, with the checksum word = 0.
  - Words: 4500, TotLen = 28 + len, ID, 4000 (DF set), 4011 (TTL 64, UDP), 0000, and the SRC/DST IP halves.
  - One word per cycle, then 2 end-around-carry folds, then invert: 12 cycles fixed.
- HDR: emit 28 bytes in network order (MSB first). This is the IPv4 header followed by the UDP header: SRC_PORT, DST_PORT, UdpLen = 8 + len, checksum 0000. A byte is emitted per cycle only when Fifo_Afull = 0.
- PLD:
  - Pld_Ready = (state == PLD) & ~Fifo_Afull.
  - Each accepted byte is written to the FIFO; a down-counter decrements per accepted byte.
  - Pld_Valid low inserts bubbles with no write.
  - After the last byte, go to PAD (when the feature is enabled and len < 18), else DONE.
- DONE: Eth_Pkt_Rdy = 1 for one cycle, the ID counter increments (wraps FFFF→0000), Busy drops the following cycle, and the state returns to IDLE.
- Outputs: Eth_Byte and Eth_Byte_Valid are registered, one cycle after the state decision. Eth_Pkt_Rdy is never asserted in the same cycle as Eth_Byte_Valid; it follows the last write by at least 1 cycle.
- If Fifo_Afull rises mid-header or mid-payload, writes stop cleanly the next decision cycle; no byte is lost or duplicated.

Optional Feature:
- Macro: ETH_UDP_PAD_EN.
- Defined: when len < 18, zero bytes are appended after the payload (state PAD, same Fifo_Afull stall rule) so FIFO payload ≥ 46 bytes. TotLen and UdpLen still reflect the true len.
- Undefined: no PAD state; exactly 28 + len bytes are written, and minimum-frame padding is left to the transmitter.

Test Plan:
- Reset, Start, len = 18, payload 0x00..0x11, Fifo_Afull = 0:
  - Busy rises and 12 CSUM cycles pass.
  - 46 consecutive writes: 45 00 00 2E 00 00 40 00 40 11 B6 0B C0 A8 01 64 C0 A8 01 FF 13 88 13 89 00 1A 00 00 00..11.
  - Eth_Pkt_Rdy pulses once afterwards.
- Repeat the same packet: ID = 0001 and checksum bytes = B6 0A.
- Same packet with Fifo_Afull held high for 5 cycles at header byte 10 and again at payload byte 3: the byte stream is identical to the first scenario; no writes and Pld_Ready = 0 during the stalls.
- Start with len = 0, and separately len = 1473: Len_Err pulses one cycle, Busy stays 0, no writes. Start while Busy: no effect.
- With ETH_UDP_PAD_EN, len = 1, payload AB: 46 writes, byte 28 = AB, bytes 29..45 = 00, TotLen = 001D, UdpLen = 0009. Without the macro: 29 writes.
- Rst_n low for 2 cycles while in PLD after 5 payload bytes: outputs go to 0 immediately (asynchronously), no Eth_Pkt_Rdy. The next len = 18 Start produces ID 0000 and checksum B6 0B.
